// File: rtl/t_ff_pkg.sv
// Shared constants and helpers for the toggle flip-flop and its prescaler.
package t_ff_pkg;

   localparam int DIV_MIN = 1;

   // Counter width for a divide-by-div prescaler (never narrower than one bit).
   function automatic int cnt_width(input int div);
      int w;
      w = $clog2(div);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/t_ff_prescaler.sv
// Divide-by-DIV strobe: tick is high on the qualifying edge where the count wraps.
// DIV=1 collapses to a wire (tick = en).
module t_ff_prescaler
   import t_ff_pkg::*;
#(
   parameter int DIV = 1
)
(
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   generate
      if (DIV < DIV_MIN) begin : g_bad_div
         $error("t_ff_prescaler: DIV must be >= %0d", DIV_MIN);
      end else if (DIV == 1) begin : g_div1
         logic unused_clk_reset;
         assign unused_clk_reset = clk ^ reset;
         assign tick = en;
      end else begin : g_divn
         localparam int CW = cnt_width(DIV);
         localparam logic [CW-1:0] LAST = CW'(DIV - 1);

         // Power-up value doubles as the FPGA init so the count is never X.
         logic [CW-1:0] cnt = '0;

         always_ff @(posedge clk or posedge reset) begin
            if (reset)   cnt <= '0;
            else if (en) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
         end

         assign tick = en && (cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/t_ff.sv
// Toggle flip-flop with optional divide-by-DIV prescaler; Q toggles once per DIV qualifying edges.
// Optional toggle-enable input t is enabled by defining T_FF_TOGGLE_INPUT_EN.
module t_ff
   import t_ff_pkg::*;
#(
   parameter logic RESET_VALUE = 1'b0,
   parameter int   DIV         = 1
)
(
   input  logic clk,
   input  logic reset,
`ifdef T_FF_TOGGLE_INPUT_EN
   input  logic t,
`endif
   output logic Q
);

   logic en;
   logic tick;

`ifdef T_FF_TOGGLE_INPUT_EN
   assign en = t;
`else
   assign en = 1'b1;
`endif

   t_ff_prescaler #(.DIV(DIV)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .tick  (tick)
   );

   // Q comes straight from this flop; the init value covers designs that never pulse reset.
   logic q_r = RESET_VALUE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     q_r <= RESET_VALUE;
      else if (tick) q_r <= ~q_r;
   end

   assign Q = q_r;

endmodule

// File: tb/tb_t_ff.sv
// Self-checking bench for t_ff: DIV=1 (RESET_VALUE=0) and DIV=3 (RESET_VALUE=1) side by side,
// compared every cycle against an edge-count model, plus directed literal checks.
module tb_t_ff;

   localparam logic RV1 = 1'b0;
   localparam logic RV3 = 1'b1;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic t     = 1'b1;
   logic q1, q3;

   int checks   = 0;
   int failures = 0;
   int n        = 0;   // qualifying edges since the last reset

   always #10 clk = ~clk;

   t_ff #(.RESET_VALUE(RV1), .DIV(1)) dut1 (
      .clk   (clk),
      .reset (reset),
`ifdef T_FF_TOGGLE_INPUT_EN
      .t     (t),
`endif
      .Q     (q1)
   );

   t_ff #(.RESET_VALUE(RV3), .DIV(3)) dut3 (
      .clk   (clk),
      .reset (reset),
`ifdef T_FF_TOGGLE_INPUT_EN
      .t     (t),
`endif
      .Q     (q3)
   );

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Model: Q = RESET_VALUE xor parity of completed DIV-edge groups since reset.
   always @(posedge clk) if (!reset && t) n = n + 1;
   always @(posedge reset) n = 0;

   always @(posedge clk) begin
      #5;
      check("model_div1", q1, RV1 ^ logic'(n % 2));
      check("model_div3", q3, RV3 ^ logic'((n / 3) % 2));
   end

   initial begin
      #5;
      check("init_div1", q1, 1'b0);
      check("init_div3", q3, 1'b1);

      // Five free-running edges (10..90ns)
      repeat (5) @(posedge clk);
      #6;
      check("five_edges_div1", q1, 1'b1);
      check("five_edges_div3", q3, 1'b0);

      // Long reset from 100ns to 300ns
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset_immediate_div1", q1, 1'b0);
      check("reset_immediate_div3", q3, 1'b1);
      repeat (10) @(negedge clk);
      check("reset_held_div1", q1, 1'b0);
      check("reset_held_div3", q3, 1'b1);
      reset = 1'b0;

      // Edges 310..390, then reset pulse 400..451
      @(negedge clk);
      repeat (4) @(negedge clk);
      check("before_pulse_div1", q1, 1'b1);
      reset = 1'b1;
      #1;
      check("pulse_clear_div1", q1, 1'b0);
      #50;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("resume_470_div1", q1, 1'b1);

      // Async assertion in the high phase, well before the next edge
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async_div1", q1, 1'b0);
      check("async_div3", q3, 1'b1);
      @(negedge clk);
      reset = 1'b0;

      // DIV=3: reset after two edges, then three fresh edges are needed
      repeat (2) @(posedge clk);
      #1;
      check("div3_two_edges", q3, 1'b1);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("div3_fresh_two", q3, 1'b1);
      @(posedge clk);
      #1;
      check("div3_fresh_three", q3, 1'b0);

`ifdef T_FF_TOGGLE_INPUT_EN
      // t=0 holds both Q and the prescaler count
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0; t = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("t_hold_div1", q1, 1'b0);
      check("t_hold_div3", q3, 1'b1);
      @(negedge clk); t = 1'b1;
      @(posedge clk);
      #1;
      check("t_resume_div1", q1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check("t_resume_div3", q3, 1'b0);
`endif

      // Randomized traffic: sync reset changes, mid-high async pulses, random t
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 15) == 0);
`ifdef T_FF_TOGGLE_INPUT_EN
         t = ($urandom_range(0, 3) != 0);
`endif
         if (!reset && $urandom_range(0, 24) == 0) begin
            @(posedge clk);
            #3;
            reset = 1'b1;
            #1;
            check("rand_async_div1", q1, RV1);
            check("rand_async_div3", q3, RV3);
            @(negedge clk);
            reset = 1'b0;
         end
      end

      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
